// File: rtl/line_mem_responder.sv
// Line memory responder: 4-word line fills and writebacks with a configurable read latency.
// Optional macro LINE_RESP_ADDR_CHECK_EN rejects out-of-range line indices with an err pulse.
module line_mem_responder #(
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic [1:0]  beat,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int LINE_W = $clog2(DEPTH_LINES);
  localparam int ADDR_W = LINE_W + 2;
  localparam int WORDS  = DEPTH_LINES * 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_WAIT  = 3'd2,
    RD_BURST = 3'd3,
    DONE     = 3'd4
  } state_t;

  logic [31:0]       r_mem [WORDS];
  state_t            r_state;
  logic [LINE_W-1:0] r_line;
  logic [1:0]        r_beat;
  logic [1:0]        r_rd_idx;
  logic              r_rd_fin;
  logic [3:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [LINE_W-1:0] w_req_line;
  logic              w_addr_bad;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [ADDR_W-1:0] w_mem_raddr;

  assign w_req_line  = req_addr[LINE_W-1:0];
  assign w_mem_raddr = {r_line, r_rd_idx};

`ifdef LINE_RESP_ADDR_CHECK_EN
  assign w_addr_bad = (req_addr >= 32'(DEPTH_LINES));
`else
  // Upper index bits are don't-care: the line index wraps modulo DEPTH_LINES.
  logic w_unused_addr_bits;
  assign w_addr_bad         = 1'b0;
  assign w_unused_addr_bits = ^req_addr[31:LINE_W];
`endif

  // Memory write-enable and address for the current cycle.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = {r_line, r_beat};
    if (RST) begin
      w_mem_we = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_mem_waddr = {w_req_line, 2'd0};
          if (req_write && !w_addr_bad) begin
            w_mem_we = 1'b1;
          end else begin
            w_mem_we = 1'b0;
          end
        end
        WR_BURST: begin
          w_mem_we    = req_write;
          w_mem_waddr = {r_line, r_beat};
        end
        default: begin
          w_mem_we = 1'b0;
        end
      endcase
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= wdata;
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_line   <= {LINE_W{1'b0}};
      r_beat   <= 2'd0;
      r_rd_idx <= 2'd0;
      r_rd_fin <= 1'b0;
      r_cnt    <= 4'd0;
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_beat   <= 2'd0;
          r_rvalid <= 1'b0;
          if ((req_write || req_read) && w_addr_bad) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end else if (req_write) begin
            r_line  <= w_req_line;
            r_beat  <= 2'd1;
            r_busy  <= 1'b1;
            r_state <= WR_BURST;
          end else if (req_read) begin
            r_line   <= w_req_line;
            r_cnt    <= 4'(LATENCY);
            r_rd_idx <= 2'd0;
            r_rd_fin <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= (LATENCY == 0) ? RD_BURST : RD_WAIT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        WR_BURST: begin
          if (!req_write) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_beat  <= 2'd0;
          end else if (r_beat == 2'd3) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_beat  <= 2'd0;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        RD_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= RD_BURST;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // rdata is a registered read, so each beat appears the cycle after its address.
        RD_BURST: begin
          if (r_rd_fin) begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b1;
            r_beat   <= 2'd0;
            r_state  <= DONE;
          end else begin
            r_rdata  <= r_mem[w_mem_raddr];
            r_rvalid <= 1'b1;
            r_beat   <= r_rd_idx;
            r_rd_idx <= r_rd_idx + 2'd1;
            r_rd_fin <= (r_rd_idx == 2'd3);
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_beat   <= 2'd0;
          r_rvalid <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_beat   <= 2'd0;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign beat   = r_beat;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: two instances (LATENCY 2 and 0) share stimulus and are
// checked against an array model of the line store and per-cycle timing arithmetic.
module tb_line_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [1:0]  beat_a, beat_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [DEPTH][4];
  logic [31:0] m_last [2];

  always #5 CLK = ~CLK;

  line_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(LAT_A)) dut_a (
    .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .wdata(wdata), .rdata(rdata_a), .rvalid(rvalid_a),
    .beat(beat_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  line_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(LAT_B)) dut_b (
    .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .wdata(wdata), .rdata(rdata_b), .rvalid(rvalid_b),
    .beat(beat_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int sel, input logic e_busy, input logic e_done,
                           input logic e_rvalid, input logic [1:0] e_beat,
                           input logic [31:0] e_rdata, input logic e_err);
    logic [31:0] g_rdata;
    logic        g_busy, g_done, g_rvalid, g_err;
    logic [1:0]  g_beat;
    if (sel == 0) begin
      g_rdata = rdata_a; g_busy = busy_a; g_done = done_a;
      g_rvalid = rvalid_a; g_err = err_a; g_beat = beat_a;
    end else begin
      g_rdata = rdata_b; g_busy = busy_b; g_done = done_b;
      g_rvalid = rvalid_b; g_err = err_b; g_beat = beat_b;
    end
    check_eq($sformatf("%s[%0d].busy", tag, sel), 32'(g_busy), 32'(e_busy));
    check_eq($sformatf("%s[%0d].done", tag, sel), 32'(g_done), 32'(e_done));
    check_eq($sformatf("%s[%0d].rvalid", tag, sel), 32'(g_rvalid), 32'(e_rvalid));
    check_eq($sformatf("%s[%0d].beat", tag, sel), 32'(g_beat), 32'(e_beat));
    check_eq($sformatf("%s[%0d].rdata", tag, sel), g_rdata, e_rdata);
    check_eq($sformatf("%s[%0d].err", tag, sel), 32'(g_err), 32'(e_err));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_both(input string tag);
    for (int s = 0; s < 2; s++) begin
      check_dut(tag, s, 1'b0, 1'b0, 1'b0, 2'd0, m_last[s], 1'b0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
`ifdef LINE_RESP_ADDR_CHECK_EN
    return 32'($urandom_range(0, DEPTH - 1));
`else
    return ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, DEPTH - 1));
`endif
  endfunction

  // Read one line; c counts edges after the accepting edge.
  task automatic do_read(input logic [31:0] addr);
    int line;
    line = int'(addr % 32'(DEPTH));
    req_read = 1'b1; req_addr = addr;
    tick();
    req_read = 1'b0; req_addr = $urandom();
    for (int c = 0; c <= LAT_A + 6; c++) begin
      for (int s = 0; s < 2; s++) begin
        int   lat;
        int   bi;
        logic v;
        lat = (s == 0) ? LAT_A : LAT_B;
        v   = (c >= lat + 1) && (c <= lat + 4);
        bi  = v ? (c - lat - 1) : 0;
        if (v) m_last[s] = m_mem[line][bi];
        check_dut("rd", s, (c <= lat + 5), (c == lat + 5), v, 2'(bi), m_last[s], 1'b0);
      end
      tick();
    end
  endtask

  // Write nb beats (4 = full burst, fewer = abort); optional simultaneous read at start.
  task automatic do_write(input logic [31:0] addr, input int nb, input logic with_rd);
    logic [31:0] w [4];
    int line;
    int last_e;
    line = int'(addr % 32'(DEPTH));
    for (int i = 0; i < 4; i++) w[i] = $urandom();
    req_write = 1'b1; req_read = with_rd; req_addr = addr; wdata = w[0];
    tick();
    m_mem[line][0] = w[0];
    req_read = 1'b0;
    last_e = (nb == 4) ? 4 : nb;
    for (int e = 0; e <= last_e; e++) begin
      logic       eb, ed;
      logic [1:0] ebt;
      if (nb == 4) begin
        eb = (e <= 3); ed = (e == 3); ebt = (e < 3) ? 2'(e + 1) : 2'd0;
      end else begin
        eb = (e < nb); ed = 1'b0; ebt = (e < nb) ? 2'(e + 1) : 2'd0;
      end
      for (int s = 0; s < 2; s++) check_dut("wr", s, eb, ed, 1'b0, ebt, m_last[s], 1'b0);
      if (e + 1 < nb) begin
        req_write = 1'b1; wdata = w[e + 1];
        m_mem[line][e + 1] = w[e + 1];
      end else begin
        req_write = 1'b0; wdata = $urandom();
      end
      // A read presented while in DONE must be ignored.
      req_read = (nb == 4) && (e == 3);
      tick();
    end
    req_read = 1'b0;
  endtask

`ifdef LINE_RESP_ADDR_CHECK_EN
  task automatic do_bad(input logic [31:0] addr, input logic is_wr);
    req_write = is_wr; req_read = !is_wr; req_addr = addr; wdata = $urandom();
    tick();
    req_write = 1'b0; req_read = 1'b0;
    for (int s = 0; s < 2; s++) check_dut("bad", s, 1'b0, 1'b0, 1'b0, 2'd0, m_last[s], 1'b1);
    tick();
    check_idle_both("bad_after");
  endtask
`endif

  initial begin
    logic [31:0] w0, w1;
    RST = 1'b1; req_read = 1'b1; req_write = 1'b1; req_addr = 32'd5; wdata = 32'hDEAD_BEEF;
    m_last[0] = 32'd0; m_last[1] = 32'd0;
    // Reset dominates concurrent requests.
    for (int i = 0; i < 3; i++) tick();
    check_idle_both("rst_hold");
    RST = 1'b0; req_read = 1'b0; req_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle_both("idle");
    end

    for (int l = 0; l < DEPTH; l++) do_write(32'(l), 4, 1'b0);

    do_write(32'd5, 4, 1'b0);
    do_read(32'd5);
    do_write(32'd7, 4, 1'b1);
    check_idle_both("wr_prio_idle");
    do_read(32'd7);
    do_write(32'd3, 2, 1'b0);
    do_read(32'd3);

    // Reset in the middle of a write keeps beats already written.
    w0 = $urandom(); w1 = $urandom();
    req_write = 1'b1; req_addr = 32'd9; wdata = w0;
    tick(); m_mem[9][0] = w0;
    wdata = w1;
    tick(); m_mem[9][1] = w1;
    RST = 1'b1; wdata = $urandom();
    tick();
    m_last[0] = 32'd0; m_last[1] = 32'd0;
    check_idle_both("rst_mid_wr");
    RST = 1'b0; req_write = 1'b0;
    tick();
    check_idle_both("post_rst_wr");
    do_read(32'd9);

    // Reset in the middle of a read clears the output registers.
    req_read = 1'b1; req_addr = 32'd12;
    tick();
    req_read = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    RST = 1'b1;
    tick();
    m_last[0] = 32'd0; m_last[1] = 32'd0;
    check_idle_both("rst_mid_rd");
    RST = 1'b0;
    tick();
    check_idle_both("post_rst_rd");

`ifdef LINE_RESP_ADDR_CHECK_EN
    do_bad(32'd64, 1'b0);
    do_bad(32'hFFFF_FFC0, 1'b1);
    do_read(32'd0);
`else
    do_read(32'd64);
    do_write(32'h0000_1047, 4, 1'b0);
    do_read(32'd7);
`endif

    for (int n = 0; n < 30; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0: do_write(rand_addr(), 4, 1'b0);
        1: do_write(rand_addr(), int'($urandom_range(1, 3)), 1'b0);
        2: do_read(rand_addr());
        default: do_write(rand_addr(), 4, 1'b1);
      endcase
    end
    do_read(32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LINES, default 64, number of 4-word lines stored.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between read accept and first read beat (0..15).
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_read  input  1  line-fill request from cache controller.
REQ-006 SHALL have port req_write  input  1  line-writeback request, held high for 4 beats.
REQ-007 SHALL have port req_addr  input  32  line index; bits [$clog2(DEPTH_LINES)-1:0] select the line.
REQ-008 SHALL have port wdata  input  32  writeback word for the current beat.
REQ-009 SHALL have port rdata  output  32  registered read word.
REQ-010 SHALL have port rvalid  output  1  rdata holds a valid beat.
REQ-011 SHALL have port beat  output  2  index of current write or read beat.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at transaction completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse on rejected request (see Configuration).

Function
REQ-015 SHALL implement states IDLE, WR_BURST, RD_WAIT, RD_BURST, DONE.
REQ-016 SHALL store DEPTH_LINES x 4 x 32-bit words; word address = {line, beat}.
REQ-017 IDLE: req_write=1 SHALL latch line, write wdata to beat 0 that cycle, set beat=1, go WR_BURST.
REQ-018 IDLE: req_write and req_read both high SHALL give write priority; read ignored.
REQ-019 WR_BURST: each cycle with req_write=1 SHALL write wdata at current beat, increment beat; after beat 3 written, go DONE.
REQ-020 WR_BURST: req_write=0 SHALL abort to IDLE; written beats kept, no done pulse.
REQ-021 IDLE: req_read=1 (req_write=0) SHALL latch line, load wait counter with LATENCY, go RD_WAIT, or RD_BURST directly if LATENCY=0.
REQ-022 RD_WAIT: SHALL decrement counter each cycle; go RD_BURST the cycle it reaches 0; req_read ignored after accept.
REQ-023 RD_BURST: SHALL drive rvalid=1 and rdata=mem[line][beat] for beats 0,1,2,3 on 4 consecutive cycles, then go DONE.
REQ-024 First rvalid SHALL occur LATENCY+1 cycles after the accepting edge; total read = LATENCY+5 cycles to done.
REQ-025 DONE: done=1, busy=1, beat=0, one cycle; then IDLE; requests in DONE ignored.
REQ-026 rvalid SHALL be 0 outside RD_BURST; rdata SHALL hold last value when rvalid=0.
REQ-027 beat SHALL wrap 3->0 only via DONE/IDLE, never mid-burst.
REQ-028 Write to a line during read of same line is impossible (single outstanding transaction); no forwarding required.

Reset
REQ-029 RST=1 SHALL force IDLE, beat=0, wait counter=0, rdata=0, rvalid=0, done=0, err=0, busy=0.
REQ-030 RST mid-burst SHALL abort the transaction; words already written SHALL remain; memory array not cleared.
REQ-031 RST SHALL dominate any concurrent request.

Configuration
REQ-032 Macro LINE_RESP_ADDR_CHECK_EN defined: request in IDLE with req_addr >= DEPTH_LINES SHALL pulse err one cycle, stay IDLE, no memory access, no done.
REQ-033 Macro undefined: err tied 0; req_addr upper bits ignored, index wraps modulo DEPTH_LINES.

Verification
REQ-034 Reset, then idle 5 cycles -> busy=0, rvalid=0, done=0, err=0, rdata=0.
REQ-035 Write line 5 words A0..A3 over 4 cycles, then read line 5, LATENCY=2 -> rvalid 3 cycles after accept, rdata A0,A1,A2,A3, beat 0..3, done 1 cycle later.
REQ-036 LATENCY=0 read line 5 -> rvalid on cycle after accept; done on cycle 5.
REQ-037 req_read and req_write both high in IDLE at line 7 -> write burst runs, no rvalid until separate read request.
REQ-038 req_write dropped after beat 1 on line 3 -> IDLE, no done; subsequent read returns new beats 0-1, old beats 2-3.
REQ-039 With LINE_RESP_ADDR_CHECK_EN, DEPTH_LINES=64, read addr 64 -> err pulse, busy stays 0; without macro -> reads line 0.
